ram_responder: RTL and testbench
================================

# ram_responder

Word-addressed, single-port RAM responder serving the core's data-memory request interface. It accepts one read or write request at a time, inserts a configurable number of wait states, and reports progress on a `ram_state_t` status output (RAM_IDLE / RAM_WAIT / RAM_DONE). It also provides load-reserved / store-conditional reservation tracking for the LR_SC opcode group. It is the memory-side end of the protocol the datapath drives.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LATENCY, 2: wait-state cycles spent in RAM_WAIT per access; range 0–15.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- nrst  in  1  Reset, asynchronous assert, active-low.
- ren  in  1  Read request.
- wen  in  1  Write request; takes priority over ren when both are high.
- lr  in  1  Qualifies ren as load-reserved.
- sc  in  1  Qualifies wen as store-conditional.
- addr  in  32 (word_t)  Byte address. Bits [1:0] are ignored.
- store_data  in  32 (word_t)  Write data.
- strobe  in  4  Byte enables; bit i writes byte lane i (SB/SH/SW masks).
- load_data  out  32 (word_t)  Read data; valid only while state==RAM_DONE.
- state  out  2 (ram_state_t)  Access status.
- sc_success  out  1  Valid while state==RAM_DONE for an SC access; 1 means the write was performed.

## Operation
- Index: index = addr[2 +: log2(DEPTH_WORDS)]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS.
- FSM states and transitions:
  - RAM_IDLE: if (wen|ren) is high, latch the operation, index, store_data, strobe, lr and sc. Go to RAM_WAIT if LATENCY>0, otherwise go directly to RAM_DONE.
  - RAM_WAIT: a down-counter is loaded with LATENCY−1 on entry and decrements each cycle. Go to RAM_DONE when the counter is 0.
  - RAM_DONE: lasts exactly one cycle, then returns to RAM_IDLE unconditionally.
- Abort: if ren and wen are both low during RAM_WAIT, return to RAM_IDLE. No write occurs and the reservation is unchanged.
- Write commit: occurs on the clock edge that enters RAM_DONE. Only the byte lanes with strobe[i]=1 change. strobe=0000 is a legal no-op write.
- Read: load_data is registered on entry to RAM_DONE from the latched index. It holds its value until the next RAM_DONE and is not cleared on return to RAM_IDLE.
- Reservation (a valid bit plus an index):
  - An LR read sets valid=1 and records the index.
  - An SC write succeeds only if valid=1 and the index matches. On success the write is performed and sc_success=1. On failure memory is untouched and sc_success=0. Any SC clears valid.
  - A plain write whose index matches the reservation clears valid.
  - sc_success is 0 for all non-SC accesses.
- The initiator must hold its request and qualifiers stable until it sees RAM_DONE, then deassert them in the following cycle. A request still high in RAM_IDLE starts a new access.
- Memory contents are not reset.

## Timing
- Reset values: state=RAM_IDLE, load_data=0, sc_success=0, reservation valid=0, wait counter=0.
- Reset mid-access: returns to RAM_IDLE immediately. A write not yet committed is lost.
- Latency from request sampled in RAM_IDLE to RAM_DONE: LATENCY+1 cycles.
- Back-to-back throughput: one access every LATENCY+2 cycles, because a RAM_IDLE cycle is always inserted.
- Read-after-write to the same index returns the new data: the write commits before the later read is sampled.
- ren and wen high together are treated as a write. The read data for that access is the pre-write content.

## Test plan
- Reset, then hold idle: state=RAM_IDLE, load_data=0, sc_success=0 on every cycle.
- LATENCY=2. Write 0xDEADBEEF to 0x10 with strobe=1111, then read 0x10. RAM_DONE appears 3 cycles after each request; the read returns 0xDEADBEEF.
- Write 0x000000AA with strobe=0001 to 0x10 over 0xDEADBEEF -> read returns 0xDEADBEAA. Then write 0x12340000 with strobe=1100 -> read returns 0x1234BEAA.
- LR 0x20, then SC 0x20 with 0x55: sc_success=1 and memory=0x55. A second SC 0x20 gives sc_success=0 and memory is unchanged. LR 0x20, plain write to 0x20, then SC: sc_success=0.
- Wrap: DEPTH_WORDS=1024. Write 0x1 to 0x1000, then read 0x0 -> returns 0x1. Read 0x3 -> same word as 0x0.
- Drop wen during RAM_WAIT -> returns to RAM_IDLE, no RAM_DONE, memory unchanged. Assert nrst low mid-RAM_WAIT -> state=RAM_IDLE asynchronously and no write occurs. LATENCY=0 -> RAM_DONE on the cycle after the request.

Source files
------------

// File: rtl/ram_responder.sv
// Word-addressed single-port RAM responder with configurable wait states and
// load-reserved / store-conditional reservation tracking.
module ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        ren_i,
  input  logic        wen_i,
  input  logic        lr_i,
  input  logic        sc_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  strobe_i,
  output logic [31:0] load_data_o,
  output logic [1:0]  state_o,
  output logic        sc_success_o
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam bit          ZeroLat  = (LATENCY == 0);
  localparam logic [3:0]  CntInit  = ZeroLat ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    RamIdle = 2'd0,
    RamWait = 2'd1,
    RamDone = 2'd2
  } ram_state_t;

  ram_state_t        state_q;
  logic [3:0]        cnt_q;
  logic              wr_q, lr_q, sc_q;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;
  logic              rsv_valid_q;
  logic [IdxW-1:0]   rsv_idx_q;
  logic [31:0]       load_data_q;
  logic              sc_success_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              req;
  logic              use_in;
  logic              cur_wr, cur_lr, cur_sc;
  logic [IdxW-1:0]   cur_idx;
  logic [31:0]       cur_data;
  logic [3:0]        cur_strb;
  logic              go_done;
  logic              sc_ok;
  logic              mem_we;

  logic unused_addr;
  assign unused_addr = ^{addr_i[1:0], addr_i[31:2+IdxW]};

  assign req    = ren_i | wen_i;
  // With zero latency the access completes straight out of idle, using live inputs.
  assign use_in = (state_q == RamIdle);

  always_comb begin
    cur_wr   = wr_q;
    cur_lr   = lr_q & ~wr_q;
    cur_sc   = sc_q & wr_q;
    cur_idx  = idx_q;
    cur_data = data_q;
    cur_strb = strb_q;
    if (use_in) begin
      cur_wr   = wen_i;
      cur_lr   = lr_i & ~wen_i;
      cur_sc   = sc_i & wen_i;
      cur_idx  = addr_i[2 +: IdxW];
      cur_data = store_data_i;
      cur_strb = strobe_i;
    end
  end

  assign go_done = ZeroLat ? (state_q == RamIdle && req)
                           : (state_q == RamWait && req && cnt_q == 4'd0);
  assign sc_ok   = ~cur_sc | (rsv_valid_q && rsv_idx_q == cur_idx);
  assign mem_we  = nrst_i & go_done & cur_wr & sc_ok;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= RamIdle;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      lr_q         <= 1'b0;
      sc_q         <= 1'b0;
      idx_q        <= '0;
      data_q       <= 32'd0;
      strb_q       <= 4'd0;
      rsv_valid_q  <= 1'b0;
      rsv_idx_q    <= '0;
      load_data_q  <= 32'd0;
      sc_success_q <= 1'b0;
    end else begin
      sc_success_q <= 1'b0;
      if (go_done) begin
        // Non-blocking read returns pre-write content for a combined ren/wen access.
        load_data_q  <= mem_q[cur_idx];
        sc_success_q <= cur_sc & sc_ok;
        if (cur_wr) begin
          if (cur_sc || cur_idx == rsv_idx_q) rsv_valid_q <= 1'b0;
        end else if (cur_lr) begin
          rsv_valid_q <= 1'b1;
          rsv_idx_q   <= cur_idx;
        end
      end
      unique case (state_q)
        RamIdle: begin
          if (req) begin
            wr_q   <= wen_i;
            lr_q   <= lr_i;
            sc_q   <= sc_i;
            idx_q  <= addr_i[2 +: IdxW];
            data_q <= store_data_i;
            strb_q <= strobe_i;
            if (ZeroLat) begin
              state_q <= RamDone;
            end else begin
              state_q <= RamWait;
              cnt_q   <= CntInit;
            end
          end
        end
        RamWait: begin
          if (!req) state_q <= RamIdle;
          else if (cnt_q == 4'd0) state_q <= RamDone;
          else cnt_q <= cnt_q - 4'd1;
        end
        RamDone: state_q <= RamIdle;
        default: state_q <= RamIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_strb[b]) mem_q[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  assign load_data_o  = load_data_q;
  assign state_o      = state_q;
  assign sc_success_o = sc_success_q;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench: directed steps plus random accesses against a word/byte
// level memory and reservation model, on a LATENCY=2 and a LATENCY=0 instance.
module tb_ram_responder;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        ren, wen, lr, sc;
  logic [31:0] addr, sdata;
  logic [3:0]  strb;
  logic [31:0] load;
  logic [1:0]  state;
  logic        scs;

  logic        z_ren, z_wen, z_lr, z_sc;
  logic [31:0] z_addr, z_sdata;
  logic [3:0]  z_strb;
  logic [31:0] z_load;
  logic [1:0]  z_state;
  logic        z_scs;

  ram_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk_i(clk), .nrst_i(nrst), .ren_i(ren), .wen_i(wen), .lr_i(lr), .sc_i(sc),
    .addr_i(addr), .store_data_i(sdata), .strobe_i(strb),
    .load_data_o(load), .state_o(state), .sc_success_o(scs)
  );

  ram_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk_i(clk), .nrst_i(nrst), .ren_i(z_ren), .wen_i(z_wen), .lr_i(z_lr), .sc_i(z_sc),
    .addr_i(z_addr), .store_data_i(z_sdata), .strobe_i(z_strb),
    .load_data_o(z_load), .state_o(z_state), .sc_success_o(z_scs)
  );

  localparam logic [1:0] SIdle = 2'd0, SWait = 2'd1, SDone = 2'd2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, one copy per instance: memory bytes, known-byte mask, reservation.
  logic [31:0] mm [2][1024];
  logic [3:0]  kn [2][1024];
  bit          rv [2];
  int          ri [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit z, input bit w, r, l, s, input logic [31:0] a, d,
                       input logic [3:0] st);
    if (z) begin
      z_wen = w; z_ren = r; z_lr = l; z_sc = s; z_addr = a; z_sdata = d; z_strb = st;
    end else begin
      wen = w; ren = r; lr = l; sc = s; addr = a; sdata = d; strb = st;
    end
  endtask

  function automatic logic [1:0] st_of(input bit z);
    return z ? z_state : state;
  endfunction

  // One complete access: update model, drive, check state sequence and results.
  task automatic access(input bit z, input bit w, r, l, s, input logic [31:0] a, d,
                        input logic [3:0] st);
    int m, idx, lat;
    logic [31:0] expl, mask, obs_load;
    bit ok, expsc;
    m    = z ? 1 : 0;
    lat  = z ? 0 : 2;
    idx  = int'(a[11:2]);
    expl = mm[m][idx];
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{kn[m][idx][b]}};
    expsc = 1'b0;
    ok    = 1'b0;
    if (w) begin
      if (s) begin
        ok    = rv[m] && ri[m] == idx;
        expsc = ok;
        rv[m] = 1'b0;
      end else begin
        ok = 1'b1;
        if (rv[m] && ri[m] == idx) rv[m] = 1'b0;
      end
      if (ok) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) begin
            mm[m][idx][8*b +: 8] = d[8*b +: 8];
            kn[m][idx][b] = 1'b1;
          end
        end
      end
    end else if (l) begin
      rv[m] = 1'b1;
      ri[m] = idx;
    end
    drive(z, w, r, l, s, a, d, st);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_state", 32'(st_of(z)), 32'(SWait));
    end
    @(negedge clk);
    chk("done_state", 32'(st_of(z)), 32'(SDone));
    obs_load = z ? z_load : load;
    chk("load_data", obs_load & mask, expl & mask);
    chk("sc_success", 32'(z ? z_scs : scs), 32'(expsc));
    drive(z, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("back_idle", 32'(st_of(z)), 32'(SIdle));
    chk("load_hold", z ? z_load : load, obs_load);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      rv[m] = 1'b0;
      ri[m] = 0;
      for (int i = 0; i < 1024; i++) begin
        kn[m][i] = 4'd0;
        mm[m][i] = 32'd0;
      end
    end
    nrst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Reset state held while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_state", 32'(state), 32'(SIdle));
      chk("rst_load", load, 32'd0);
      chk("rst_sc", 32'(scs), 32'd0);
      chk("rst_state0", 32'(z_state), 32'(SIdle));
    end

    // Full write then read
    access(0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 4'b1111);
    access(0, 0, 1, 0, 0, 32'h10, 32'd0, 4'd0);
    chk("rd_deadbeef", load, 32'hDEADBEEF);

    // Byte and halfword strobes
    access(0, 1, 0, 0, 0, 32'h10, 32'h000000AA, 4'b0001);
    access(0, 0, 1, 0, 0, 32'h10, 32'd0, 4'd0);
    chk("rd_sb", load, 32'hDEADBEAA);
    access(0, 1, 0, 0, 0, 32'h10, 32'h12340000, 4'b1100);
    access(0, 0, 1, 0, 0, 32'h10, 32'd0, 4'd0);
    chk("rd_sh", load, 32'h1234BEAA);

    // LR/SC
    access(0, 0, 1, 1, 0, 32'h20, 32'd0, 4'd0);
    access(0, 1, 0, 0, 1, 32'h20, 32'h55, 4'b1111);
    access(0, 0, 1, 0, 0, 32'h20, 32'd0, 4'd0);
    chk("rd_sc_ok", load, 32'h55);
    access(0, 1, 0, 0, 1, 32'h20, 32'h77, 4'b1111);
    access(0, 0, 1, 0, 0, 32'h20, 32'd0, 4'd0);
    chk("rd_sc_fail", load, 32'h55);
    access(0, 0, 1, 1, 0, 32'h20, 32'd0, 4'd0);
    access(0, 1, 0, 0, 0, 32'h20, 32'h66, 4'b1111);
    access(0, 1, 0, 0, 1, 32'h20, 32'h99, 4'b1111);
    access(0, 0, 1, 0, 0, 32'h20, 32'd0, 4'd0);
    chk("rd_sc_broken", load, 32'h66);

    // Address wrap and ignored low bits
    access(0, 1, 0, 0, 0, 32'h1000, 32'h1, 4'b1111);
    access(0, 0, 1, 0, 0, 32'h0, 32'd0, 4'd0);
    chk("rd_wrap", load, 32'h1);
    access(0, 0, 1, 0, 0, 32'h3, 32'd0, 4'd0);
    chk("rd_lowbits", load, 32'h1);

    // Combined ren+wen: write, pre-write read data
    access(0, 1, 1, 0, 0, 32'h10, 32'hA5A5A5A5, 4'b1111);
    chk("rw_preread", load, 32'h1234BEAA);

    // Abort during wait
    drive(0, 1, 0, 0, 0, 32'h10, 32'h0BAD0BAD, 4'b1111);
    @(negedge clk);
    chk("abort_wait", 32'(state), 32'(SWait));
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("abort_idle", 32'(state), 32'(SIdle));
    @(negedge clk);
    chk("abort_no_done", 32'(state), 32'(SIdle));
    access(0, 0, 1, 0, 0, 32'h10, 32'd0, 4'd0);
    chk("abort_mem", load, 32'hA5A5A5A5);

    // Asynchronous reset mid-wait
    drive(0, 1, 0, 0, 0, 32'h10, 32'hCAFEF00D, 4'b1111);
    @(negedge clk);
    chk("rstw_wait", 32'(state), 32'(SWait));
    #1 nrst = 1'b0;
    #1;
    chk("rstw_state", 32'(state), 32'(SIdle));
    chk("rstw_load", load, 32'd0);
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    nrst = 1'b1;
    @(negedge clk);
    access(0, 0, 1, 0, 0, 32'h10, 32'd0, 4'd0);
    chk("rstw_mem", load, 32'hA5A5A5A5);

    // Zero-latency instance
    access(1, 1, 0, 0, 0, 32'h44, 32'h13572468, 4'b1111);
    access(1, 0, 1, 0, 0, 32'h44, 32'd0, 4'd0);
    chk("z_rd", z_load, 32'h13572468);

    // Random accesses on both instances
    for (int it = 0; it < 60; it++) begin
      bit z, w, r, l, s;
      int kind;
      logic [31:0] a;
      z    = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 4));
      a    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 2)
             | 32'($urandom_range(0, 3));
      w = (kind >= 2) && (kind != 1);
      r = (kind <= 1) || (kind == 4);
      l = (kind == 1);
      s = (kind == 3);
      access(z, w, r, l, s, a, $urandom, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
